// File: rtl/johnson_seq_ctrl.sv
// Johnson-counter sequencer: runs ROTS full 8-step rotations in a latched direction,
// with pause (HOLD), cancel (ABORT) and a one-cycle DONE pulse on normal completion.
`timescale 1ns/1ps
module johnson_seq_ctrl #(
  parameter int N_W = 4
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic           START,
  input  logic [N_W-1:0] ROTS,
  input  logic           DIR,
  input  logic           HOLD,
  input  logic           ABORT,
  output logic [3:0]     COUNT,
  output logic [2:0]     PHASE,
  output logic           BUSY,
  output logic           DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HELD
  } state_t;

  state_t         r_state;
  logic [3:0]     r_count;
  logic [2:0]     r_phase;
  logic [N_W-1:0] r_rem;
  logic           r_dir;
  logic           r_busy;
  logic           r_done;

  logic [3:0]     w_next;
  logic           w_wrap;

  function automatic logic isJohnson(input logic [3:0] c);
    case (c)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] phaseOf(input logic [3:0] c);
    case (c)
      4'b1000: return 3'd1;
      4'b1100: return 3'd2;
      4'b1110: return 3'd3;
      4'b1111: return 3'd4;
      4'b0111: return 3'd5;
      4'b0011: return 3'd6;
      4'b0001: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Illegal codes collapse to 0000 so the counter self-recovers on the next step.
  function automatic logic [3:0] stepCode(input logic [3:0] c, input logic dir);
    if (!isJohnson(c)) return 4'b0000;
    return dir ? {c[2:0], ~c[3]} : {~c[0], c[3:1]};
  endfunction

  always_comb begin
    w_next = stepCode(r_count, r_dir);
    w_wrap = isJohnson(r_count) && (w_next == 4'b0000);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_count <= 4'b0000;
      r_phase <= 3'd0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ABORT) begin
        r_state <= S_IDLE;
        r_count <= 4'b0000;
        r_phase <= 3'd0;
        r_rem   <= '0;
        r_busy  <= 1'b0;
      end else if (HOLD) begin
        if (r_state == S_RUN) begin
          r_state <= S_HELD;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_count <= 4'b0000;
            r_phase <= 3'd0;
            if (START) begin
              if (ROTS != '0) begin
                r_rem   <= ROTS;
                r_dir   <= DIR;
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          S_RUN: begin
            r_count <= w_next;
            r_phase <= phaseOf(w_next);
            // A completed rotation is counted on the edge that lands back on 0000.
            if (w_wrap) begin
              r_rem <= r_rem - 1'b1;
              if (r_rem == N_W'(1)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_HELD: begin
            r_state <= S_RUN;
          end
          default: begin
            r_state <= S_IDLE;
            r_count <= 4'b0000;
            r_phase <= 3'd0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign COUNT = r_count;
  assign PHASE = r_phase;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: the driver queues hand-computed expectations
// per clock edge and an independent monitor pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_johnson_seq_ctrl;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rots  = 4'd0;
  logic       dir   = 1'b0;
  logic       hold  = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic [2:0] phase;
  logic       busy;
  logic       done;

  int nVectors     = 0;
  int nMiscompares = 0;

  typedef struct {
    string      name;
    logic [3:0] expCount;
    logic       expBusy;
    logic       expDone;
  } exp_t;

  exp_t scoreQ[$];

  logic [3:0] fwdSeq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                             4'b0111, 4'b0011, 4'b0001, 4'b0000};
  logic [3:0] revSeq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] phaseTbl [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                               4'b1111, 4'b0111, 4'b0011, 4'b0001};

  johnson_seq_ctrl #(.N_W(4)) dut (
    .CLK   (clock),
    .CLR   (clear),
    .START (start),
    .ROTS  (rots),
    .DIR   (dir),
    .HOLD  (hold),
    .ABORT (abort),
    .COUNT (count),
    .PHASE (phase),
    .BUSY  (busy),
    .DONE  (done)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] expPhaseOf(input logic [3:0] c);
    for (int k = 0; k < 8; k++) begin
      if (phaseTbl[k] == c) return 3'(k);
    end
    return 3'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] expCount,
                             input logic expBusy, input logic expDone);
    logic [2:0] expPhase;
    expPhase = expPhaseOf(expCount);
    nVectors++;
    if (count !== expCount || phase !== expPhase || busy !== expBusy || done !== expDone) begin
      nMiscompares++;
      $display("[TB] FAIL %s @%0t: got COUNT=%b PHASE=%0d BUSY=%b DONE=%b, expected COUNT=%b PHASE=%0d BUSY=%b DONE=%b",
               name, $time, count, phase, busy, done, expCount, expPhase, expBusy, expDone);
    end
  endtask

  // Drives one edge worth of inputs and queues what the outputs must show after that edge.
  task automatic applyStimulus(input string name, input logic iStart, input logic [3:0] iRots,
                               input logic iDir, input logic iHold, input logic iAbort,
                               input logic [3:0] expCount, input logic expBusy, input logic expDone);
    exp_t e;
    start = iStart;
    rots  = iRots;
    dir   = iDir;
    hold  = iHold;
    abort = iAbort;
    @(posedge clock);
    e.name     = name;
    e.expCount = expCount;
    e.expBusy  = expBusy;
    e.expDone  = expDone;
    scoreQ.push_back(e);
    #2;
  endtask

  task automatic stepRun(input string name, input logic isRev, input int nSteps,
                         input int firstIdx, input logic endsRun);
    logic [3:0] c;
    logic       last;
    for (int i = 0; i < nSteps; i++) begin
      c    = isRev ? revSeq[(firstIdx + i) % 8] : fwdSeq[(firstIdx + i) % 8];
      last = endsRun && (i == nSteps - 1);
      applyStimulus(name, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, c, !last, last);
    end
  endtask

  task automatic idleCycle(input string name);
    applyStimulus(name, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  // Monitor: every falling edge with a pending expectation is a compare point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput(e.name, e.expCount, e.expBusy, e.expDone);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d",
             nVectors, nMiscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 clear = 1'b1;
    #1 checkOutput("resetAsync", 4'b0000, 1'b0, 1'b0);
    @(negedge clock);
    clear = 1'b0;

    // Single forward rotation, with a mid-run START/DIR/ROTS change that must be ignored.
    applyStimulus("fwdStart", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("fwd1", 1'b0, 2, 0, 1'b0);
    applyStimulus("ignoreStart", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0);
    stepRun("fwd1", 1'b0, 5, 3, 1'b1);
    idleCycle("fwd1After");

    // Two reverse rotations.
    applyStimulus("revStart", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("rev2", 1'b1, 16, 0, 1'b1);
    idleCycle("rev2After");

    // HOLD for three cycles at 1110 stretches the run to 12 edges.
    applyStimulus("holdStart", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("holdPre", 1'b0, 3, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("holdFrozen", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'b1110, 1'b1, 1'b0);
    applyStimulus("holdBubble", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0);
    stepRun("holdPost", 1'b0, 5, 3, 1'b1);
    idleCycle("holdAfter");

    // HOLD on the completing edge wins over completion.
    applyStimulus("lastHoldStart", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("lastHoldPre", 1'b0, 7, 0, 1'b0);
    applyStimulus("lastHoldWin", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);
    applyStimulus("lastHoldBubble", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0);
    stepRun("lastHoldEnd", 1'b0, 1, 7, 1'b1);
    idleCycle("lastHoldAfter");

    // ABORT at 1111, immediate restart, then abort that too.
    applyStimulus("abortStart", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("abortPre", 1'b0, 4, 0, 1'b0);
    applyStimulus("abortHit", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    applyStimulus("abortRestart", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("abortRestartStep", 1'b1, 1, 0, 1'b0);
    applyStimulus("abortAgain", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    idleCycle("abortNoDone");
    idleCycle("abortNoDone2");

    // ABORT together with START in IDLE starts nothing.
    applyStimulus("abortStartIdle", 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    idleCycle("abortStartIdleAfter");

    // ROTS=0 gives an immediate DONE; ROTS=15 takes 120 edges.
    applyStimulus("rotsZero", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    idleCycle("rotsZeroAfter");
    applyStimulus("rotsMaxStart", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("rotsMax", 1'b0, 120, 0, 1'b1);
    idleCycle("rotsMaxAfter");

    // Asynchronous clear mid-run, then a START on the very first edge afterwards.
    applyStimulus("clrStart", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("clrPre", 1'b0, 5, 0, 1'b0);
    @(negedge clock);
    #1 clear = 1'b1;
    #1 checkOutput("clrMidRun", 4'b0000, 1'b0, 1'b0);
    @(negedge clock);
    clear = 1'b0;
    applyStimulus("clrRestart", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    stepRun("clrRun", 1'b0, 8, 0, 1'b1);
    idleCycle("clrAfter");

    for (int i = 0; i < 4 && scoreQ.size() > 0; i++) @(negedge clock);
    #1;
    if (scoreQ.size() > 0) begin
      nMiscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", scoreQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
